// File: rtl/mandelbrot_pkg.sv
// ============================================================================
// Module      : mandelbrot_pkg
// Description : Shared definitions for the Mandelbrot raster engine: FSM
//               state encoding, default fixed-point format and the escape
//               threshold helper.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mandelbrot_pkg;

    // Default fixed-point format: Q3.12 in a 16-bit signed word.
    localparam int DEF_DATA_W = 16;
    localparam int DEF_FRAC_W = 12;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_INIT = 3'd1,
        ST_ITER = 3'd2,
        ST_OUT  = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    // |z|^2 bound of 4.0 expressed in the fixed-point scale.
    function automatic int esc_threshold(input int frac_w);
        return 4 << frac_w;
    endfunction

endpackage : mandelbrot_pkg

`default_nettype wire

// File: rtl/mandel_iter_step.sv
// ============================================================================
// Module      : mandel_iter_step
// Description : Purely combinational single iteration of z <- z^2 + c in
//               signed fixed point, plus the escape test on the current z.
// Ports       : i_zr/i_zi  current z (signed, DATA_W)
//               i_cr/i_ci  pixel constant c (signed, DATA_W)
//               o_zr_nxt/o_zi_nxt  next z, truncated to DATA_W (wraps)
//               o_escape   1 when |z|^2 > 4.0 (strict)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mandel_iter_step
    import mandelbrot_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int FRAC_W = DEF_FRAC_W
) (
    input  logic [DATA_W-1:0] i_zr,
    input  logic [DATA_W-1:0] i_zi,
    input  logic [DATA_W-1:0] i_cr,
    input  logic [DATA_W-1:0] i_ci,
    output logic [DATA_W-1:0] o_zr_nxt,
    output logic [DATA_W-1:0] o_zi_nxt,
    output logic              o_escape
);

    localparam int W2 = 2 * DATA_W;
    localparam logic signed [W2-1:0] c_esc_th = W2'(esc_threshold(FRAC_W));

    // Sign-extend before multiplying so the products are computed at full width.
    logic signed [W2-1:0] w_zr_x;
    logic signed [W2-1:0] w_zi_x;
    logic signed [W2-1:0] w_zr_sq;
    logic signed [W2-1:0] w_zi_sq;
    logic signed [W2-1:0] w_zrzi;
    logic signed [W2-1:0] w_zr2;
    logic signed [W2-1:0] w_zi2;
    logic signed [W2-1:0] w_mag;

    assign w_zr_x  = {{DATA_W{i_zr[DATA_W-1]}}, i_zr};
    assign w_zi_x  = {{DATA_W{i_zi[DATA_W-1]}}, i_zi};

    assign w_zr_sq = w_zr_x * w_zr_x;
    assign w_zi_sq = w_zi_x * w_zi_x;
    assign w_zrzi  = w_zr_x * w_zi_x;

    assign w_zr2   = w_zr_sq >>> FRAC_W;
    assign w_zi2   = w_zi_sq >>> FRAC_W;
    assign w_mag   = w_zr2 + w_zi2;

    assign o_escape = (w_mag > c_esc_th);

    // 2*zr*zi folds the doubling into a shift of FRAC_W-1 instead of FRAC_W.
    // Results are truncated to DATA_W, so overflow wraps in two's complement.
    assign o_zr_nxt = DATA_W'(w_zr2 - w_zi2) + i_cr;
    assign o_zi_nxt = DATA_W'(w_zrzi >>> (FRAC_W - 1)) + i_ci;

endmodule : mandel_iter_step

`default_nettype wire

// File: rtl/mandelbrot_engine.sv
// ============================================================================
// Module      : mandelbrot_engine
// Description : Walks an H_PIX x V_PIX raster of complex points, iterates
//               z <- z^2 + c per pixel until escape or MAX_ITER, and streams
//               one iteration count per pixel over a valid/ready handshake.
// Ports       : Clk_100M, Rst_n (async active-low)
//               start, start_x/start_y, step_x/step_y   frame request
//               busy, frame_done                         frame status
//               pix_valid/pix_ready, pix_iter, pix_col,
//               pix_row, pix_last                        pixel stream
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mandelbrot_engine
    import mandelbrot_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int FRAC_W   = DEF_FRAC_W,
    parameter int MAX_ITER = 255,
    parameter int ITER_W   = 8,
    parameter int H_PIX    = 640,
    parameter int V_PIX    = 480,
    parameter int COL_W    = 10,
    parameter int ROW_W    = 9
) (
    input  logic              Clk_100M,
    input  logic              Rst_n,
    input  logic              start,
    input  logic [DATA_W-1:0] start_x,
    input  logic [DATA_W-1:0] start_y,
    input  logic [DATA_W-1:0] step_x,
    input  logic [DATA_W-1:0] step_y,
    output logic              busy,
    output logic              pix_valid,
    input  logic              pix_ready,
    output logic [ITER_W-1:0] pix_iter,
    output logic [COL_W-1:0]  pix_col,
    output logic [ROW_W-1:0]  pix_row,
    output logic              pix_last,
    output logic              frame_done
);

    localparam logic [COL_W-1:0]  c_last_col = COL_W'(H_PIX - 1);
    localparam logic [ROW_W-1:0]  c_last_row = ROW_W'(V_PIX - 1);
    localparam logic [ITER_W-1:0] c_max_iter = ITER_W'(MAX_ITER);

    state_t              r_state;
    state_t              w_state_nxt;

    logic [DATA_W-1:0]   r_start_x;
    logic [DATA_W-1:0]   r_step_x;
    logic [DATA_W-1:0]   r_step_y;
    logic [DATA_W-1:0]   r_cr;
    logic [DATA_W-1:0]   r_ci;
    logic [DATA_W-1:0]   r_zr;
    logic [DATA_W-1:0]   r_zi;
    logic [ITER_W-1:0]   r_iter;
    logic [ITER_W-1:0]   r_pix_iter;
    logic [COL_W-1:0]    r_col;
    logic [ROW_W-1:0]    r_row;

    logic [DATA_W-1:0]   w_zr_nxt;
    logic [DATA_W-1:0]   w_zi_nxt;
    logic                w_escape;
    logic                w_pix_done;
    logic                w_end_row;
    logic                w_last_pos;
    logic                w_handshake;

    mandel_iter_step #(
        .DATA_W (DATA_W),
        .FRAC_W (FRAC_W)
    ) u_step (
        .i_zr     (r_zr),
        .i_zi     (r_zi),
        .i_cr     (r_cr),
        .i_ci     (r_ci),
        .o_zr_nxt (w_zr_nxt),
        .o_zi_nxt (w_zi_nxt),
        .o_escape (w_escape)
    );

    assign w_pix_done  = w_escape || (r_iter == c_max_iter);
    assign w_end_row   = (r_col == c_last_col);
    assign w_last_pos  = w_end_row && (r_row == c_last_row);
    assign w_handshake = (r_state == ST_OUT) && pix_ready;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge Clk_100M or negedge Rst_n) begin
        if (!Rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (start)       w_state_nxt = ST_INIT;
            ST_INIT:                  w_state_nxt = ST_ITER;
            ST_ITER: if (w_pix_done)  w_state_nxt = ST_OUT;
            ST_OUT:  if (w_handshake) w_state_nxt = w_last_pos ? ST_DONE : ST_INIT;
            ST_DONE:                  w_state_nxt = ST_IDLE;
            default:                  w_state_nxt = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs (decoded from registered state only, so pix_valid has
    // no combinational path from pix_ready)
    // ------------------------------------------------------------------
    always_comb begin
        busy       = 1'b0;
        pix_valid  = 1'b0;
        frame_done = 1'b0;
        case (r_state)
            ST_INIT: busy = 1'b1;
            ST_ITER: busy = 1'b1;
            ST_OUT: begin
                busy      = 1'b1;
                pix_valid = 1'b1;
            end
            ST_DONE: frame_done = 1'b1;
            default: ;
        endcase
    end

    assign pix_iter = r_pix_iter;
    assign pix_col  = r_col;
    assign pix_row  = r_row;
    // Gated by pix_valid so a 1x1 raster does not flag last while idle.
    assign pix_last = pix_valid && w_last_pos;

    // ------------------------------------------------------------------
    // Datapath: raster walk, z registers and iteration counter
    // ------------------------------------------------------------------
    always_ff @(posedge Clk_100M or negedge Rst_n) begin
        if (!Rst_n) begin
            r_start_x  <= '0;
            r_step_x   <= '0;
            r_step_y   <= '0;
            r_cr       <= '0;
            r_ci       <= '0;
            r_zr       <= '0;
            r_zi       <= '0;
            r_iter     <= '0;
            r_pix_iter <= '0;
            r_col      <= '0;
            r_row      <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_start_x <= start_x;
                        r_step_x  <= step_x;
                        r_step_y  <= step_y;
                        r_cr      <= start_x;
                        r_ci      <= start_y;
                        r_col     <= '0;
                        r_row     <= '0;
                    end
                end
                ST_INIT: begin
                    r_zr   <= '0;
                    r_zi   <= '0;
                    r_iter <= '0;
                end
                ST_ITER: begin
                    if (w_pix_done) begin
                        r_pix_iter <= r_iter;
                    end else begin
                        r_zr   <= w_zr_nxt;
                        r_zi   <= w_zi_nxt;
                        r_iter <= r_iter + 1'b1;
                    end
                end
                ST_OUT: begin
                    if (pix_ready) begin
                        if (w_end_row) begin
                            r_col <= '0;
                            r_cr  <= r_start_x;
                            r_row <= r_row + 1'b1;
                            // Imaginary axis runs downward as rows advance.
                            r_ci  <= r_ci - r_step_y;
                        end else begin
                            r_col <= r_col + 1'b1;
                            r_cr  <= r_cr + r_step_x;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule : mandelbrot_engine

`default_nettype wire

// File: tb/tb_mandelbrot_engine.sv
// ============================================================================
// Module      : tb_mandelbrot_engine
// Description : Self-checking bench for mandelbrot_engine. A 1x1 instance
//               covers single-point behaviour from a vector table; a 4x2
//               instance covers raster order, backpressure, reset abort,
//               start-while-busy and randomized frames against a reference
//               model built from the escape-time definition.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mandelbrot_engine;

    localparam int DW = 16;
    localparam int IW = 8;
    localparam int CW = 10;
    localparam int RW = 9;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [DW-1:0] sx, sy, stx, sty;

    logic          p_start, p_ready, p_busy, p_valid, p_last, p_done;
    logic [IW-1:0] p_iter;
    logic [CW-1:0] p_col;
    logic [RW-1:0] p_row;

    logic          r_start, r_ready, r_busy, r_valid, r_last, r_done;
    logic [IW-1:0] r_iter;
    logic [CW-1:0] r_col;
    logic [RW-1:0] r_row;

    always #5 clk = ~clk;

    mandelbrot_engine #(.H_PIX(1), .V_PIX(1)) u_pt (
        .Clk_100M (clk),     .Rst_n     (rst_n),
        .start    (p_start), .start_x   (sx),      .start_y  (sy),
        .step_x   (stx),     .step_y    (sty),
        .busy     (p_busy),  .pix_valid (p_valid), .pix_ready(p_ready),
        .pix_iter (p_iter),  .pix_col   (p_col),   .pix_row  (p_row),
        .pix_last (p_last),  .frame_done(p_done)
    );

    mandelbrot_engine #(.H_PIX(4), .V_PIX(2)) u_ras (
        .Clk_100M (clk),     .Rst_n     (rst_n),
        .start    (r_start), .start_x   (sx),      .start_y  (sy),
        .step_x   (stx),     .step_y    (sty),
        .busy     (r_busy),  .pix_valid (r_valid), .pix_ready(r_ready),
        .pix_iter (r_iter),  .pix_col   (r_col),   .pix_row  (r_row),
        .pix_last (r_last),  .frame_done(r_done)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Escape-time count straight from the definition, Q3.12, 16-bit wrap.
    function automatic int ref_iter(input shortint cr, input shortint ci);
        shortint zr = 0;
        shortint zi = 0;
        shortint nzi;
        longint  a, b;
        for (int it = 0; it <= 255; it++) begin
            a = (longint'(zr) * longint'(zr)) >>> 12;
            b = (longint'(zi) * longint'(zi)) >>> 12;
            if (a + b > 64'sd16384) return it;
            if (it == 255) return it;
            nzi = shortint'(((longint'(zr) * longint'(zi)) >>> 11) + longint'(ci));
            zr  = shortint'(a - b + longint'(cr));
            zi  = nzi;
        end
        return 255;
    endfunction

    typedef struct {
        logic [15:0] cr;
        logic [15:0] ci;
        int          it;
    } pt_vec_t;

    pt_vec_t vecs[6];

    task automatic run_point(input pt_vec_t v, input int idx);
        int lat;
        sx = v.cr; sy = v.ci;
        @(posedge clk); #1 p_start = 1'b1;
        @(posedge clk); #1 p_start = 1'b0;
        lat = 0;
        while (!p_valid && lat < 400) begin
            @(posedge clk); #1;
            lat++;
        end
        check($sformatf("pt%0d latency", idx), lat, v.it + 2);
        check($sformatf("pt%0d iter", idx), p_iter, v.it);
        check($sformatf("pt%0d last/busy", idx), {p_last, p_busy}, 2'b11);
        p_ready = 1'b1;
        @(posedge clk); #1 p_ready = 1'b0;
        check($sformatf("pt%0d done/busy/valid", idx), {p_done, p_busy, p_valid}, 3'b100);
        @(posedge clk); #1;
        check($sformatf("pt%0d after done", idx), {p_done, p_busy}, 2'b00);
    endtask

    // Runs one 4x2 frame and checks every accepted pixel against the model.
    task automatic run_frame(input logic [15:0] a, input logic [15:0] b,
                             input logic [15:0] c, input logic [15:0] d,
                             input bit rnd, input bit inject, input string tag);
        int          e_col[8], e_row[8], e_it[8];
        int          got;
        bit          pend, hold, fin, rdy;
        logic [28:0] snap;
        logic [15:0] cr, ci;
        for (int p = 0; p < 8; p++) begin
            e_col[p] = p % 4;
            e_row[p] = p / 4;
            cr = 16'(int'(a) + e_col[p] * int'(c));
            ci = 16'(int'(b) - e_row[p] * int'(d));
            e_it[p] = ref_iter(shortint'(cr), shortint'(ci));
        end
        sx = a; sy = b; stx = c; sty = d;
        @(posedge clk); #1 r_start = 1'b1;
        @(posedge clk); #1 r_start = 1'b0;
        got = 0; pend = 0; hold = 0; fin = 0; snap = '0;
        for (int cyc = 0; cyc < 6000 && !fin; cyc++) begin
            if (pend) begin
                check({tag, " frame_done"}, {r_done, r_busy, r_valid}, 3'b100);
                fin = 1;
            end else begin
                if (hold)
                    check({tag, " hold stable"}, {r_valid, r_iter, r_col, r_row, r_last}, snap);
                if (inject && cyc == 20) begin
                    r_start = 1'b1;
                    sx      = 16'h5555;
                end else begin
                    r_start = 1'b0;
                end
                if (r_valid) begin
                    rdy     = rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
                    r_ready = rdy;
                    snap    = {r_valid, r_iter, r_col, r_row, r_last};
                    hold    = !rdy;
                    if (rdy) begin
                        check($sformatf("%s pix%0d", tag, got),
                              {r_col, r_row, r_iter, r_last},
                              {CW'(e_col[got]), RW'(e_row[got]), IW'(e_it[got]), got == 7});
                        pend = (got == 7);
                        got++;
                    end
                end else begin
                    hold    = 0;
                    r_ready = rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
                end
                @(posedge clk); #1;
            end
        end
        r_ready = 1'b0;
        r_start = 1'b0;
        if (!fin) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s timeout: got %0d pixels expected 8", tag, got);
        end else begin
            @(posedge clk); #1;
            check({tag, " idle after done"}, {r_done, r_busy}, 2'b00);
        end
    endtask

    initial begin
        int          w;
        logic [28:0] snap;

        rst_n = 1'b0;
        p_start = 0; p_ready = 0; r_start = 0; r_ready = 0;
        sx = '0; sy = '0; stx = '0; sty = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        check("reset pt outs", {p_busy, p_valid, p_iter, p_col, p_row, p_last, p_done}, '0);
        check("reset ras outs", {r_busy, r_valid, r_iter, r_col, r_row, r_last, r_done}, '0);

        // Hand-derived single points: c=0, 2.0 (|z|^2==4 exactly at iter 1
        // must not escape), -1.0, i, 2.0+lsb (just above 4.0), -8.0.
        vecs[0] = '{16'h0000, 16'h0000, 255};
        vecs[1] = '{16'h2000, 16'h0000, 2};
        vecs[2] = '{16'hF000, 16'h0000, 255};
        vecs[3] = '{16'h0000, 16'h1000, 255};
        vecs[4] = '{16'h2001, 16'h0000, 1};
        vecs[5] = '{16'h8000, 16'h0000, 1};
        for (int i = 0; i < 6; i++) run_point(vecs[i], i);

        // Backpressure on the first raster pixel, then reset abort in ITER of (2,0).
        sx = 16'h0000; sy = 16'h1000; stx = 16'h0033; sty = 16'h004C;
        @(posedge clk); #1 r_start = 1'b1;
        @(posedge clk); #1 r_start = 1'b0;
        w = 0;
        while (!r_valid && w < 400) begin @(posedge clk); #1; w++; end
        check("bp first valid", r_valid, 1'b1);
        snap = {r_valid, r_iter, r_col, r_row, r_last};
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            check($sformatf("bp hold %0d", k), {r_valid, r_iter, r_col, r_row, r_last}, snap);
        end
        check("bp pixel", {r_col, r_row, r_iter}, {CW'(0), RW'(0), IW'(ref_iter(16'sh0000, 16'sh1000))});
        r_ready = 1'b1;
        @(posedge clk); #1 r_ready = 1'b0;
        check("bp single advance", {r_valid, r_col, r_row}, {1'b0, CW'(1), RW'(0)});
        r_ready = 1'b1;
        w = 0;
        while (!(r_col == 2 && !r_valid) && w < 2000) begin @(posedge clk); #1; w++; end
        r_ready = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check("pre-reset in ITER", {r_busy, r_valid, r_col}, {1'b1, 1'b0, CW'(2)});
        rst_n = 1'b0;
        #1;
        check("async reset outs", {r_busy, r_valid, r_iter, r_col, r_row, r_last, r_done}, '0);
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;
        check("post reset idle", {r_busy, r_valid, r_done}, 3'b000);

        // Restarted reference raster, with an ignored start pulse mid-frame.
        run_frame(16'h0000, 16'h1000, 16'h0033, 16'h004C, 1'b0, 1'b1, "raster");

        for (int f = 0; f < 3; f++) begin
            run_frame(16'(int'($urandom_range(0, 12288)) - 8192),
                      16'(int'($urandom_range(0, 8192)) - 4096),
                      16'($urandom_range(0, 512)),
                      16'($urandom_range(0, 512)),
                      1'b1, 1'b0, $sformatf("rand%0d", f));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_mandelbrot_engine

`default_nettype wire

// File: doc/mandelbrot_engine.md
Name: mandelbrot_engine

Overview:
- Parametrised successor to the single-point fractal iterator.
- Walks a full H_PIX × V_PIX raster of complex points, starting at (start_x, start_y) and advancing by step_x / step_y.
- For each pixel, iterates z ← z² + c in signed fixed point until escape or MAX_ITER.
- Streams one iteration count per pixel on a valid/ready handshake to the colour-map/framebuffer writer.

Parameters:
- DATA_W, 16: signed fixed-point width of coordinates and z.
- FRAC_W, 12: fractional bits (Q3.12 default, 1.0 = 0x1000).
- MAX_ITER, 255: iteration cap; must fit in ITER_W bits.
- ITER_W, 8: width of the iteration count output.
- H_PIX, 640: pixels per row.
- V_PIX, 480: rows per frame.
- COL_W, 10: column index width, ≥ clog2(H_PIX).
- ROW_W, 9: row index width, ≥ clog2(V_PIX).

Ports:
- Clk_100M  in  1  system clock, all logic on rising edge.
- Rst_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle frame start request.
- start_x  in  DATA_W  real part of top-left pixel.
- start_y  in  DATA_W  imaginary part of top-left pixel.
- step_x  in  DATA_W  real increment per column.
- step_y  in  DATA_W  imaginary decrement per row.
- busy  out  1  frame in progress.
- pix_valid  out  1  pixel result available.
- pix_ready  in  1  consumer accepts pixel.
- pix_iter  out  ITER_W  iteration count of current pixel.
- pix_col  out  COL_W  column of current pixel.
- pix_row  out  ROW_W  row of current pixel.
- pix_last  out  1  current pixel is (H_PIX-1, V_PIX-1).
- frame_done  out  1  one-cycle pulse at end of frame.

Behaviour:
- Reset (async assert, synchronous release): state IDLE; busy=0, pix_valid=0, pix_iter=0, pix_col=0, pix_row=0, pix_last=0, frame_done=0; all datapath registers 0.
- Reset asserted mid-frame aborts immediately; no partial pixel is emitted.
- IDLE:
  - start=1 latches start_x/y and step_x/y, sets cr=start_x, ci=start_y, col=row=0, busy=1 → INIT.
  - start while busy=1 is ignored.
- INIT (1 cycle): zr=zi=0, iter=0 → ITER.
- ITER (one iteration per cycle), using the current registered zr, zi:
  - Compute zr2=(zr*zr)>>>FRAC_W, zi2=(zi*zi)>>>FRAC_W, both full 2*DATA_W signed width.
  - Escape if zr2+zi2 > (4<<FRAC_W); the comparison is strict.
  - Escape or iter==MAX_ITER: pix_iter=iter, pix_valid=1 → OUT.
  - Otherwise update:
    - zr ← zr2 − zi2 + cr
    - zi ← ((zr*zi)>>>(FRAC_W−1)) + ci
    - iter ← iter+1
  - z updates are truncated to DATA_W and wrap in two's complement; no saturation.
- Latency: from entering INIT, pix_valid rises after (final iter + 2) cycles.
- OUT:
  - pix_valid, pix_iter, pix_col, pix_row and pix_last are held stable until pix_valid && pix_ready.
  - pix_last=1 iff col==H_PIX-1 and row==V_PIX-1.
  - On handshake, pix_valid drops next cycle and coordinates advance:
    - Not at end of row: col+1, cr+=step_x.
    - At end of row: col=0, cr=start_x, row+1, ci−=step_y.
  - Coordinate arithmetic wraps modulo 2^DATA_W.
  - Non-last pixel → INIT.
  - Last pixel → DONE.
- DONE (1 cycle): frame_done=1, busy=0 → IDLE.
  - start may be accepted on the cycle after DONE.
- pix_ready is ignored outside OUT. pix_valid never depends combinationally on pix_ready.

Decomposition:
- mandelbrot_pkg holds:
  - state enum {IDLE, INIT, ITER, OUT, DONE};
  - default DATA_W/FRAC_W constants;
  - escape-threshold helper function (4<<FRAC_W).
- One combinational sub-module, mandel_iter_step, maps zr, zi, cr, ci to next zr, next zi and escape.
- mandelbrot_engine keeps the FSM, counters, raster walk and handshake.

Test Plan:
- c=0 (start_x=start_y=0, H_PIX=V_PIX=1) → pix_iter=255, pix_last=1, frame_done pulse one cycle after handshake.
- c=2.0 (start_x=0x2000, start_y=0) → z goes 0, 2, 6; escapes at iter 2; pix_iter=2. Also confirms |z|²=4 exactly does not escape.
- c=−1.0 (0xF000) → z alternates −1/0, never escapes → pix_iter=255, valid at cycle 257 after INIT.
- Backpressure: hold pix_ready=0 for 5 cycles with pix_valid=1 → outputs stable, col/row unchanged; single advance when pix_ready=1.
- Raster H_PIX=4, V_PIX=2, start_x=0, step_x=0x0033, start_y=0x1000, step_y=0x004C, pix_ready=1:
  - 8 pixels in order (0,0)…(3,0),(0,1)…(3,1);
  - row 1 starts at cr=0, ci=0x0FB4;
  - pix_last only on (3,1); busy low after frame_done.
- Rst_n low during ITER of pixel (2,0) → all outputs at reset values asynchronously; a new start restarts the frame at (0,0). A start pulse during busy has no effect.
